// File: rtl/epcs_responder_pkg.sv
// EPCS responder shared types: FSM states, byte sources, command codes.
// No ports; imported by the responder top.
package epcs_responder_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      DUMMY,
      DATA,
      IGNORE
   } state_t;

   typedef enum logic [1:0] {
      SRC_MEM,
      SRC_STATUS,
      SRC_ID
   } src_t;

   localparam logic [7:0] CMD_READ = 8'h03;
   localparam logic [7:0] CMD_RDSR = 8'h05;
   localparam logic [7:0] CMD_RES  = 8'hAB;

   localparam int ADDR_BITS = 24;
   localparam int CNT_W     = 5;

   localparam logic [CNT_W-1:0] LAST_BYTE_BIT = CNT_W'(7);
   localparam logic [CNT_W-1:0] LAST_ADDR_BIT = CNT_W'(ADDR_BITS - 1);

endpackage

// File: rtl/epcs_responder_sync_edge.sv
// 2-flop synchronizer with one-cycle rise/fall pulses on the synced value.
// Ports: clk, rst (sync, active-high), d (async in), q, rise, fall.
module epcs_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= RST_VAL;
         s2 <= RST_VAL;
         s3 <= RST_VAL;
      end else begin
         s1 <= d;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign q    = s2;
   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;

endmodule

// File: rtl/epcs_responder.sv
// EPCS serial-flash responder: READ / RDSR / RES served from a byte store.
// Ports: clk_clk, reset_reset, epcs_* serial pins, mem_* store port, status_in, busy.
module epcs_responder
   import epcs_responder_pkg::*;
#(
   parameter int         MEM_AW     = 16,
   parameter logic [7:0] SILICON_ID = 8'h12
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic              epcs_dclk,
   input  logic              epcs_sce,
   input  logic              epcs_sdo,
   output logic              epcs_data0,
   output logic              epcs_data0_oe,
   output logic [MEM_AW-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_rdata,
   input  logic [7:0]        status_in,
   output logic              busy
);

   logic dclk_s, dclk_rise, dclk_fall;
   logic sce_s, sce_rise, sce_fall;
   logic sdo_s, sdo_rise, sdo_fall;
   logic unused_edges;

   epcs_sync_edge #(.RST_VAL(1'b0)) u_dclk (
      .clk  (clk_clk),
      .rst  (reset_reset),
      .d    (epcs_dclk),
      .q    (dclk_s),
      .rise (dclk_rise),
      .fall (dclk_fall)
   );

   epcs_sync_edge #(.RST_VAL(1'b1)) u_sce (
      .clk  (clk_clk),
      .rst  (reset_reset),
      .d    (epcs_sce),
      .q    (sce_s),
      .rise (sce_rise),
      .fall (sce_fall)
   );

   epcs_sync_edge #(.RST_VAL(1'b0)) u_sdo (
      .clk  (clk_clk),
      .rst  (reset_reset),
      .d    (epcs_sdo),
      .q    (sdo_s),
      .rise (sdo_rise),
      .fall (sdo_fall)
   );

   state_t               state;
   state_t               state_next;
   src_t                 src;
   logic [CNT_W-1:0]     bit_cnt;
   logic [ADDR_BITS-2:0] rx_sr;
   logic [ADDR_BITS-1:0] rx_word;
   logic [7:0]           tx_sr;
   logic                 ld_pend;
   logic [1:0]           warm;
   logic                 armed;
   logic                 rx_take;
   logic                 field_done;
   logic                 tx_step;

   assign rx_word = {rx_sr, sdo_s};
   assign busy    = (state != IDLE);

   assign unused_edges = ^{sce_rise, sce_fall, sdo_rise, sdo_fall,
                           dclk_s, rx_word[ADDR_BITS-1]};

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      rx_take    = 1'b0;
      field_done = 1'b0;
      tx_step    = 1'b0;
      if (sce_s) begin
         state_next = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (armed) state_next = CMD;
            end
            CMD: begin
               if (dclk_rise) begin
                  rx_take = 1'b1;
                  if (bit_cnt == LAST_BYTE_BIT) begin
                     field_done = 1'b1;
                     unique case (1'b1)
                        rx_word[7:0] == CMD_READ: state_next = ADDR;
                        rx_word[7:0] == CMD_RES:  state_next = DUMMY;
                        rx_word[7:0] == CMD_RDSR: state_next = DATA;
                        default:                  state_next = IGNORE;
                     endcase
                  end
               end
            end
            ADDR, DUMMY: begin
               if (dclk_rise) begin
                  rx_take = 1'b1;
                  if (bit_cnt == LAST_ADDR_BIT) begin
                     field_done = 1'b1;
                     state_next = DATA;
                  end
               end
            end
            DATA:    tx_step    = dclk_fall;
            IGNORE:  state_next = IGNORE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         warm          <= '0;
         armed         <= 1'b0;
         bit_cnt       <= '0;
         rx_sr         <= '0;
         tx_sr         <= '0;
         src           <= SRC_MEM;
         ld_pend       <= 1'b0;
         mem_addr      <= '0;
         mem_rd        <= 1'b0;
         epcs_data0    <= 1'b0;
         epcs_data0_oe <= 1'b0;
      end else begin
         // sce must be seen truly high (past the reset-forced value)
         // before a falling sce can start a transaction.
         warm    <= {warm[0], 1'b1};
         armed   <= armed | (warm[1] & sce_s);
         mem_rd  <= 1'b0;
         ld_pend <= mem_rd & ~sce_s;
         if (sce_s) begin
            bit_cnt       <= '0;
            rx_sr         <= '0;
            tx_sr         <= '0;
            epcs_data0    <= 1'b0;
            epcs_data0_oe <= 1'b0;
         end else begin
            if (rx_take) begin
               rx_sr   <= rx_word[ADDR_BITS-2:0];
               bit_cnt <= field_done ? '0 : bit_cnt + CNT_W'(1);
            end
            if (field_done) begin
               unique case (state)
                  CMD: begin
                     src   <= SRC_STATUS;
                     tx_sr <= status_in;
                  end
                  ADDR: begin
                     src      <= SRC_MEM;
                     mem_addr <= rx_word[MEM_AW-1:0];
                     mem_rd   <= ~mem_rd;
                  end
                  DUMMY: begin
                     src   <= SRC_ID;
                     tx_sr <= SILICON_ID;
                  end
                  default: ;
               endcase
            end
            if (ld_pend) begin
               tx_sr <= mem_rdata;
            end
            if (tx_step) begin
               epcs_data0    <= tx_sr[7];
               epcs_data0_oe <= 1'b1;
               if (bit_cnt == LAST_BYTE_BIT) begin
                  // Byte boundary: prefetch or re-sample the next byte.
                  bit_cnt <= '0;
                  unique case (src)
                     SRC_MEM: begin
                        mem_addr <= mem_addr + MEM_AW'(1);
                        mem_rd   <= ~mem_rd;
                        tx_sr    <= {tx_sr[6:0], 1'b0};
                     end
                     SRC_STATUS: tx_sr <= status_in;
                     SRC_ID:     tx_sr <= SILICON_ID;
                     default:    tx_sr <= '0;
                  endcase
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  tx_sr   <= {tx_sr[6:0], 1'b0};
               end
            end
         end
      end
   end

endmodule
